// File: rtl/sata_pkg.sv
// Shared SATA transmit constants and the 32-step scrambler LFSR advance.
package sata_pkg;

  localparam logic [15:0] SATA_SCR_POLY         = 16'hA011;
  localparam logic [15:0] SATA_SCR_SEED         = 16'hFFFF;
  localparam int          SATA_MAX_FRAME_DWORDS = 2064;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } scr_state_t;

  // Galois LFSR, 32 single-bit steps. Step k's output is stored in scr[k].
  // This bit order is what makes seed FFFF produce scr = C2D2768D.
  // Returns {next_lfsr, scr}.
  function automatic logic [47:0] scramble_advance(input logic [15:0] prior,
                                                   input logic [15:0] poly = SATA_SCR_POLY);
    logic [15:0] r;
    logic [31:0] scr;
    logic        fb;
    r   = prior;
    scr = '0;
    for (int i = 0; i < 32; i++) begin
      fb     = r[15];
      scr[i] = fb;
      r      = {r[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end
    return {r, scr};
  endfunction

endpackage

// File: rtl/satatx_scr_lfsr.sv
// 16-bit scrambler state with advance/reseed strobes; reseed wins over advance.
module satatx_scr_lfsr
  import sata_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL   = SATA_SCR_POLY,
  parameter logic [15:0] INITIAL_SEED = SATA_SCR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        reseed,
  output logic [31:0] scr
);

  logic [15:0] state;
  logic [47:0] step;

  assign step = scramble_advance(state, POLYNOMIAL);
  assign scr  = step[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INITIAL_SEED;
    end else if (reseed) begin
      state <= INITIAL_SEED;
    end else if (advance) begin
      state <= step[47:32];
    end
  end

endmodule

// File: rtl/satatx_scrambler.sv
// SATA TX scrambler: XORs each AXI-stream dword with the per-frame LFSR sequence.
// Optional SATATX_SCRAMBLER_BYPASS_EN adds i_bypass to forward data unscrambled.
//   state   | meaning
//   S_IDLE  | next accepted beat starts a frame
//   S_FRAME | inside a multi-dword frame, waiting for TLAST
module satatx_scrambler
  import sata_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL   = SATA_SCR_POLY,
  parameter logic [15:0] INITIAL_SEED = SATA_SCR_SEED,
  parameter int          MAX_DWORDS   = SATA_MAX_FRAME_DWORDS,
  parameter logic        OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_abort,
`ifdef SATATX_SCRAMBLER_BYPASS_EN
  input  logic        i_bypass,
`endif
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        o_overlength
);

  localparam logic [11:0] MAX_CNT = 12'(MAX_DWORDS);

  scr_state_t  state, state_next;
  logic [11:0] count, count_inc;
  logic        accept, reseed;
  logic [31:0] scr, beat_data;
  logic        out_valid, out_last, overlength;
  logic [31:0] out_data;

  assign S_AXIS_TREADY = (!out_valid || M_AXIS_TREADY) && !i_abort;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign reseed        = i_abort || (accept && S_AXIS_TLAST);
  assign count_inc     = (count == 12'hFFF) ? count : count + 12'd1;

`ifdef SATATX_SCRAMBLER_BYPASS_EN
  assign beat_data = i_bypass ? S_AXIS_TDATA : (S_AXIS_TDATA ^ scr);
`else
  assign beat_data = S_AXIS_TDATA ^ scr;
`endif

  satatx_scr_lfsr #(
    .POLYNOMIAL  (POLYNOMIAL),
    .INITIAL_SEED(INITIAL_SEED)
  ) u_lfsr (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .advance(accept),
    .reseed (reseed),
    .scr    (scr)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && !S_AXIS_TLAST) state_next = S_FRAME;
      S_FRAME: if (accept && S_AXIS_TLAST)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (i_abort) state_next = S_IDLE;
  end

  // The count clears on the TLAST beat, but overlength is judged on that beat's incremented value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      count      <= '0;
      overlength <= 1'b0;
    end else if (i_abort) begin
      count <= '0;
    end else if (accept) begin
      count <= S_AXIS_TLAST ? 12'd0 : count_inc;
      if (count_inc > MAX_CNT) begin
        overlength <= 1'b1;
      end else if (state == S_IDLE) begin
        overlength <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (i_abort) begin
      out_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        out_data <= '0;
        out_last <= 1'b0;
      end
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_last  <= S_AXIS_TLAST;
    end else if (M_AXIS_TREADY) begin
      out_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        out_data <= '0;
        out_last <= 1'b0;
      end
    end
  end

  assign M_AXIS_TVALID = out_valid;
  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TLAST  = out_last;
  assign o_overlength  = overlength;

endmodule

// File: tb/tb_satatx_scrambler.sv
// Scoreboard bench for satatx_scrambler; reference scrambler is the bit-serial recurrence of G(x).
`timescale 1ns/1ps
module tb_satatx_scrambler;

  localparam int MAX_DWORDS = 2064;
  localparam int SEQ_BITS   = 2100 * 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        bypass;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        overlength;

  always #5 clk = ~clk;

  satatx_scrambler dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .i_abort      (abort),
`ifdef SATATX_SCRAMBLER_BYPASS_EN
    .i_bypass     (bypass),
`endif
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TREADY(s_ready),
    .S_AXIS_TDATA (s_data),
    .S_AXIS_TLAST (s_last),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready),
    .M_AXIS_TDATA (m_data),
    .M_AXIS_TLAST (m_last),
    .o_overlength (overlength)
  );

  int          total = 0;
  int          bad   = 0;
  logic [32:0] exp_q[$];
  bit          seq[SEQ_BITS];
  logic [15:0] seq_head;
  int          frame_pos = 0;
  bit          model_ov  = 1'b0;
  bit          bp_en     = 1'b0;
  logic        stalled   = 1'b0;
  logic [32:0] held;
  logic [32:0] popped;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scrambler word k of a frame: bits 32k..32k+31 of the serial sequence, earliest bit in bit 0.
  function automatic logic [31:0] scr_word(input int k);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = seq[32 * k + i];
    return w;
  endfunction

  task automatic drive_beat(input logic [31:0] d, input logic l);
    int          waited;
    bit          done;
    logic [31:0] e;
    waited  = 0;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!done) begin
      m_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (s_ready) begin
        e = bypass ? d : (d ^ scr_word(frame_pos));
        exp_q.push_back({l, e});
        if (frame_pos + 1 > MAX_DWORDS) model_ov = 1'b1;
        else if (frame_pos == 0)        model_ov = 1'b0;
        frame_pos = l ? 0 : frame_pos + 1;
        done = 1'b1;
      end
      @(negedge clk);
      if (!done) begin
        waited++;
        if (waited > 64) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: got no TREADY expected TREADY within 64 cycles");
          done = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("overlength", 64'(overlength), 64'(model_ov));
  endtask

  task automatic send_frame(input int n, input bit chk_first);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      drive_beat(d, i == n - 1);
      if (chk_first && i == 0)
        check("frame_seed", 64'({m_valid, m_data}),
              64'({1'b1, bypass ? d : (d ^ 32'hC2D2768D)}));
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      m_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (stalled)
        check("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, held}));
      if (!m_valid)
        check("lowpower_zero", 64'({m_last, m_data}), 64'h0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
        end else begin
          popped = exp_q.pop_front();
          check("beat", 64'({m_last, m_data}), 64'(popped));
        end
      end
      stalled = m_valid && !m_ready;
      held    = {m_last, m_data};
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    seq_head = 16'h768D;
    for (int i = 0; i < 16; i++) seq[i] = seq_head[i];
    for (int n = 0; n + 16 < SEQ_BITS; n++)
      seq[n + 16] = seq[n + 15] ^ seq[n + 13] ^ seq[n + 4] ^ seq[n];

    rst_n   = 1'b0;
    abort   = 1'b0;
    bypass  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #3;
    check("rst_valid", 64'(m_valid), 64'h0);
    check("rst_data", 64'(m_data), 64'h0);
    check("rst_last", 64'(m_last), 64'h0);
    check("rst_overlength", 64'(overlength), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // three zero dwords: beat0 is the raw seed word, one clock after acceptance
    drive_beat(32'h0, 1'b0);
    check("first_word", 64'({m_valid, m_last, m_data}), 64'({2'b10, 32'hC2D2768D}));
    drive_beat(32'h0, 1'b0);
    drive_beat(32'h0, 1'b1);
    check("first_frame_last", 64'({m_valid, m_last}), 64'h3);

    // back-to-back frames, no idle cycle
    send_frame(4, 1'b1);
    send_frame(3, 1'b1);

    // backpressure on a long frame and several short ones
    bp_en = 1'b1;
    send_frame(100, 1'b0);
    for (int f = 0; f < 6; f++) send_frame($urandom_range(1, 20), 1'b0);
    bp_en = 1'b0;
    idle(4);

    // abort at beat 5 of a 10-beat frame
    for (int i = 0; i < 5; i++) drive_beat($urandom, 1'b0);
    m_ready = 1'b1;
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = $urandom;
    #1;
    check("abort_blocks_ready", 64'(s_ready), 64'h0);
    @(negedge clk);
    abort     = 1'b0;
    s_valid   = 1'b0;
    frame_pos = 0;
    check("abort_drops_valid", 64'(m_valid), 64'h0);
    send_frame(2, 1'b1);
    idle(2);

    // 2065-dword frame, then a 4-dword frame
    for (int i = 0; i < 2065; i++) begin
      drive_beat($urandom, i == 2064);
      if (i == 2063) check("ov_at_max", 64'(overlength), 64'h0);
      if (i == 2064) check("ov_rise", 64'(overlength), 64'h1);
    end
    for (int i = 0; i < 4; i++) begin
      drive_beat($urandom, i == 3);
      if (i == 0) check("ov_clear", 64'(overlength), 64'h0);
    end
    idle(2);

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 3; i++) drive_beat($urandom, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", 64'({m_valid, m_last, m_data}), 64'h0);
    check("arst_overlength", 64'(overlength), 64'h0);
    exp_q.delete();
    frame_pos = 0;
    model_ov  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(3, 1'b1);

`ifdef SATATX_SCRAMBLER_BYPASS_EN
    bypass = 1'b1;
    send_frame(3, 1'b1);
    bypass = 1'b0;
    send_frame(2, 1'b1);
`endif

    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
